// File: rtl/pulse_input_conditioner.sv
// pulse_input_conditioner: per-line sync, glitch filter, rising-edge pulse and sticky glitch flags
module pulse_input_conditioner #(
    parameter int unsigned NCH      = 9,
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned CW       = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] raw_in,
    input  logic [NCH-1:0] en_mask,
    input  logic           glitch_clr,
    output logic [NCH-1:0] level_out,
    output logic [NCH-1:0] pulse_out,
    output logic           pulse_any,
    output logic [NCH-1:0] glitch_flag
);
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

    logic [NCH-1:0]         sync1_q, sync2_q, level_q, level_d, pulse_q, pulse_d, glitch_q, glitch_d;
    logic [NCH-1:0]         commit, abort;
    logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
    logic                   any_q;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            commit[i]  = (sync2_q[i] != level_q[i]) && (cnt_q[i] == LAST);
            abort[i]   = (sync2_q[i] == level_q[i]) && (cnt_q[i] != '0);
            cnt_d[i]   = (sync2_q[i] == level_q[i] || commit[i]) ? '0 : cnt_q[i] + CW'(1);
            level_d[i] = commit[i] ? sync2_q[i] : level_q[i];
        end
        pulse_d  = commit & sync2_q & en_mask;
        // a new abort wins over a simultaneous clear
        glitch_d = abort | (glitch_clr ? '0 : glitch_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            pulse_q  <= '0;
            any_q    <= 1'b0;
            glitch_q <= '0;
        end else begin
            sync1_q  <= raw_in;
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            any_q    <= |pulse_d;
            glitch_q <= glitch_d;
        end
    end

    assign level_out   = level_q;
    assign pulse_out   = pulse_q;
    assign pulse_any   = any_q;
    assign glitch_flag = glitch_q;
endmodule

// File: tb/tb_pulse_input_conditioner.sv
// tb_pulse_input_conditioner: scoreboard of expected pulse events plus directed level/flag checks
module tb_pulse_input_conditioner;
    localparam int NCH = 9;

    typedef struct {
        int             c;
        logic [NCH-1:0] m;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] raw_in = '0;
    logic [NCH-1:0] en_mask = '1;
    logic           glitch_clr = 1'b0;
    logic [NCH-1:0] level_out, pulse_out, glitch_flag;
    logic           pulse_any;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    ev_t sb[$];

    pulse_input_conditioner #(.NCH(NCH), .FILT_LEN(4), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .raw_in(raw_in), .en_mask(en_mask), .glitch_clr(glitch_clr),
        .level_out(level_out), .pulse_out(pulse_out), .pulse_any(pulse_any), .glitch_flag(glitch_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input logic [NCH-1:0] m);
        ev_t e;
        e.c = cyc + 6;
        e.m = m;
        sb.push_back(e);
    endtask

    // pulses are popped against the scoreboard as they appear
    always @(negedge clk) begin
        ev_t e;
        if (pulse_out != '0) begin
            if (sb.size() == 0) check("unexpected_pulse", 32'(pulse_out), 32'd0);
            else begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.c);
                check("pulse_value", 32'(pulse_out), 32'(e.m));
                check("pulse_any_hi", 32'(pulse_any), 32'd1);
            end
        end else if (pulse_any !== 1'b0) check("pulse_any_idle", 32'(pulse_any), 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        check("rst_level", 32'(level_out), 32'd0);
        check("rst_glitch", 32'(glitch_flag), 32'd0);
        check("rst_pulse", 32'(pulse_out), 32'd0);
        rst_n = 1'b1;
        step(2);
        // clean rising edge on line 0
        raw_in[0] = 1'b1;
        expect_pulse(9'h001);
        step(20);
        check("l0_level", 32'(level_out), 32'h001);
        // 3-cycle glitch on line 3, then clear
        raw_in[3] = 1'b1;
        step(3);
        raw_in[3] = 1'b0;
        step(10);
        check("l3_glitch_set", 32'(glitch_flag), 32'h008);
        check("l3_level", 32'(level_out), 32'h001);
        glitch_clr = 1'b1;
        step(1);
        glitch_clr = 1'b0;
        check("l3_glitch_clr", 32'(glitch_flag), 32'h000);
        // all lines rise together with RTC masked
        raw_in = '0;
        step(12);
        check("all_low_level", 32'(level_out), 32'h000);
        en_mask = 9'h0FF;
        raw_in = 9'h1FF;
        expect_pulse(9'h0FF);
        step(12);
        check("all_level", 32'(level_out), 32'h1FF);
        check("all_glitch", 32'(glitch_flag), 32'h000);
        raw_in = '0;
        step(12);
        en_mask = '1;
        // square wave on line 1, period 20
        for (int p = 0; p < 5; p++) begin
            raw_in[1] = 1'b1;
            expect_pulse(9'h002);
            step(10);
            raw_in[1] = 1'b0;
            step(10);
        end
        step(5);
        check("l1_glitch", 32'(glitch_flag), 32'h000);
        check("l1_level", 32'(level_out), 32'h000);
        // async reset mid-filter on line 5
        raw_in[0] = 1'b1;
        expect_pulse(9'h001);
        step(10);
        check("pre_rst_level", 32'(level_out), 32'h001);
        raw_in[5] = 1'b1;
        step(4);
        #3 rst_n = 1'b0;
        #1;
        check("async_level", 32'(level_out), 32'h000);
        check("async_pulse", 32'(pulse_out), 32'h000);
        check("async_any", 32'(pulse_any), 32'h000);
        check("async_glitch", 32'(glitch_flag), 32'h000);
        step(3);
        check("held_level", 32'(level_out), 32'h000);
        rst_n = 1'b1;
        expect_pulse(9'h021);
        step(12);
        check("post_rst_level", 32'(level_out), 32'h021);
        check("post_rst_glitch", 32'(glitch_flag), 32'h000);
        // abort on line 2 in the same cycle as glitch_clr, with line 3 flag pending
        raw_in[3] = 1'b1;
        step(3);
        raw_in[3] = 1'b0;
        step(10);
        check("l3_glitch_again", 32'(glitch_flag), 32'h008);
        raw_in[2] = 1'b1;
        step(2);
        raw_in[2] = 1'b0;
        step(2);
        glitch_clr = 1'b1;
        step(1);
        glitch_clr = 1'b0;
        check("set_wins", 32'(glitch_flag), 32'h004);
        step(10);
        check("l2_level", 32'(level_out), 32'h021);
        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pulse_input_conditioner.md
Name: pulse_input_conditioner

Overview:
- Front-end stage directly upstream of the multi-channel impulse counter core. It takes the raw asynchronous channel lines (ch1..ch8) and the RTC line.
- Per line: synchronises to clk, rejects glitches shorter than FILT_LEN cycles, and emits a single-cycle count-enable pulse on each qualified rising edge.
- Sticky per-line glitch flags feed the readout path for diagnostics.

Parameters:
- NCH, 9, number of conditioned lines; bit 8 = RTC, bits 7..0 = ch8..ch1
- FILT_LEN, 4, consecutive synchronised cycles a new level must persist before acceptance; legal range 1..255
- CW, 8, filter counter width; must satisfy 2^CW > FILT_LEN

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- raw_in  in  NCH  unsynchronised channel/RTC inputs
- en_mask  in  NCH  per-line enable; 0 suppresses pulse generation only
- glitch_clr  in  1  synchronous clear of all glitch flags
- level_out  out  NCH  accepted (filtered) level per line
- pulse_out  out  NCH  one-cycle pulse per accepted rising edge
- pulse_any  out  1  OR of pulse_out, registered in the same cycle as pulse_out
- glitch_flag  out  NCH  sticky: a pending level change aborted before acceptance

Behaviour:
- Reset (rst_n=0, async):
  - Sync stages, level_out, filter counters, pulse_out, pulse_any and glitch_flag all go to 0 immediately.
  - They stay 0 while rst_n=0.
- Synchroniser: two-flop chain per line, s[i] = second flop. No other logic samples raw_in.
- Filter, per line, every clk:
  - If s[i]==level_out[i]: cnt[i]<=0.
  - Else if cnt[i]==FILT_LEN-1: level_out[i]<=s[i] and cnt[i]<=0 (commit).
  - Else: cnt[i]<=cnt[i]+1.
- Glitch detection:
  - Abort condition: s[i]==level_out[i] while cnt[i]!=0. This sets glitch_flag[i].
  - glitch_clr=1 clears all flags that cycle.
  - Simultaneous glitch_clr and a new abort on the same line: set wins (flag=1).
- Pulse generation:
  - pulse_out[i]<=commit[i] & s[i] & en_mask[i], i.e. rising commits only.
  - Falling commits never pulse.
  - pulse_out is exactly 1 cycle wide; consecutive pulses on one line are at least 2*FILT_LEN cycles apart.
- Latency:
  - raw_in rising and then held stable → pulse_out high in cycle FILT_LEN+2 after the first capturing edge.
  - level_out rises in that same cycle.
- en_mask: sampled in the commit cycle only. The filter and level_out run regardless of the mask.
- Independence: every line is fully independent. Any number of lines may pulse in the same cycle; pulse_any=1 if any do.
- Line high at reset release: level_out starts at 0, so a pulse is emitted after FILT_LEN+2 cycles. The counter core counts it; this is intended.
- Mid-filter reset: cnt cleared and no pulse; filtering restarts from level_out=0.
- FILT_LEN=1: commit on the first cycle s differs. Glitches are not possible; glitch_flag stays 0.
- No combinational path from any input to any output.

Test Plan:
- Reset then raw_in[0] 0→1 held 20 cycles, FILT_LEN=4, en_mask=all 1:
  - pulse_out[0]=1 for exactly one cycle, 6 cycles after first capture.
  - level_out[0]=1 from then on; pulse_any mirrors pulse_out[0].
- raw_in[3] high for 3 cycles then low, FILT_LEN=4:
  - No pulse; level_out[3] stays 0; glitch_flag[3]=1.
  - Pulse glitch_clr → glitch_flag[3]=0 next cycle.
- All 9 lines rise on the same cycle; en_mask=9'h0FF:
  - pulse_out=9'h0FF in one cycle; RTC bit stays 0.
  - level_out=9'h1FF.
- raw_in[1] toggles with period 20 cycles for 5 periods:
  - Exactly 5 pulses, each 1 cycle wide.
  - No pulse on falling edges; glitch_flag[1]=0.
- rst_n asserted asynchronously mid-filter (cnt=2) on line 5:
  - All outputs 0 immediately.
  - After release with raw_in[5] still high: one pulse 6 cycles later.
- Abort coinciding with glitch_clr on line 2 → glitch_flag[2]=1 afterwards (set priority).
